// File: rtl/reg_exec_pkg.sv
// Shared definitions for the register-file execute/write-back sequencer.
// Op codes, state encoding and instruction field layout.
package reg_exec_pkg;

    localparam int INSTR_W = 13;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SLT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;

    localparam int OP_HI = 12;
    localparam int OP_LO = 9;
    localparam int RD_HI = 8;
    localparam int RD_LO = 6;
    localparam int RS_HI = 5;
    localparam int RS_LO = 3;
    localparam int RT_HI = 2;
    localparam int RT_LO = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_EXEC = 3'd2,
        ST_MUL  = 3'd3,
        ST_WB   = 3'd4
    } state_t;

    typedef struct packed {
        logic [OP_HI-OP_LO:0] op;
        logic [RD_HI-RD_LO:0] rd;
        logic [RS_HI-RS_LO:0] rs;
        logic [RT_HI-RT_LO:0] rt;
    } instr_t;

endpackage

// File: rtl/reg_exec_alu.sv
// Combinational ALU for ops 0-7: 8-bit wrap-around result plus carry/borrow.
module reg_exec_alu
    import reg_exec_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [3:0]    op,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] y,
    output logic [DW-1:0] res,
    output logic          carry
);

    always_comb begin
        res   = '0;
        carry = 1'b0;
        unique case (1'b1)
            (op == OP_ADD): {carry, res} = {1'b0, x} + {1'b0, y};
            (op == OP_SUB): {carry, res} = {1'b0, x} - {1'b0, y};
            (op == OP_AND): res = x & y;
            (op == OP_OR):  res = x | y;
            (op == OP_XOR): res = x ^ y;
            (op == OP_SLT): res = {{(DW-1){1'b0}}, x < y};
            (op == OP_SHL): res = x << y[2:0];
            (op == OP_SHR): res = x >> y[2:0];
            default: ;
        endcase
    end

endmodule

// File: rtl/reg_exec_ctrl.sv
// Serialised execute/write-back sequencer in front of the 8x8 register file.
// Define REG_EXEC_MUL_EN to add the multi-cycle shift-add MUL (op 8).
module reg_exec_ctrl
    import reg_exec_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    output logic [AW-1:0]      RX,
    output logic [AW-1:0]      RY,
    input  logic [DW-1:0]      busX,
    input  logic [DW-1:0]      busY,
    output logic               WEN,
    output logic [AW-1:0]      RW,
    output logic [DW-1:0]      busW,
    output logic               done,
    output logic [DW-1:0]      result,
    output logic               zero,
    output logic               carry,
    output logic               illegal
);

    state_t        state;
    state_t        state_nx;
    instr_t        instr_q;
    logic          rd_ph;
    logic [DW-1:0] opx;
    logic [DW-1:0] opy;
    logic [AW-1:0] rx_q;
    logic [AW-1:0] ry_q;
    logic          ill_q;
    logic [DW-1:0] alu_res;
    logic          alu_c;
    logic          op_mul;
    logic          op_legal;

    reg_exec_alu #(.DW(DW)) u_alu (
        .op    (instr_q.op),
        .x     (opx),
        .y     (opy),
        .res   (alu_res),
        .carry (alu_c)
    );

`ifdef REG_EXEC_MUL_EN
    localparam int CW = $clog2(DW);

    logic [CW-1:0]   mul_cnt;
    logic [2*DW-1:0] mul_acc;
    logic [2*DW-1:0] mul_mcand;
    logic [2*DW-1:0] mul_acc_nx;
    logic [DW-1:0]   mul_mplr;
    logic            mul_last;

    assign op_mul     = (instr_q.op == OP_MUL);
    assign mul_acc_nx = mul_acc + (mul_mplr[0] ? mul_mcand : '0);
    assign mul_last   = (mul_cnt == CW'(DW-1));
`else
    assign op_mul = 1'b0;
`endif

    assign op_legal = (instr_q.op <= OP_SHR) || op_mul;
    assign RX       = rx_q;
    assign RY       = ry_q;

    always_ff @(posedge Clk) begin
        if (!Rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (in_valid) state_nx = ST_READ;
            ST_READ: if (rd_ph) state_nx = ST_EXEC;
`ifdef REG_EXEC_MUL_EN
            ST_EXEC: state_nx = op_mul ? ST_MUL : ST_WB;
            ST_MUL:  if (mul_last) state_nx = ST_WB;
`else
            ST_EXEC: state_nx = ST_WB;
`endif
            ST_WB:   state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Selects are registered in the first READ cycle; buses sampled in the second.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            instr_q <= '0;
            rd_ph   <= 1'b0;
            rx_q    <= '0;
            ry_q    <= '0;
            opx     <= '0;
            opy     <= '0;
            result  <= '0;
            zero    <= 1'b0;
            carry   <= 1'b0;
            ill_q   <= 1'b0;
`ifdef REG_EXEC_MUL_EN
            mul_cnt   <= '0;
            mul_acc   <= '0;
            mul_mcand <= '0;
            mul_mplr  <= '0;
`endif
        end else begin
            rd_ph <= (state == ST_READ) && !rd_ph;
            if (state == ST_IDLE && in_valid) instr_q <= in_instr;
            if (state == ST_READ && !rd_ph) begin
                rx_q <= AW'(instr_q.rs);
                ry_q <= AW'(instr_q.rt);
            end
            if (state == ST_READ && rd_ph) begin
                opx <= busX;
                opy <= busY;
            end
            if (state == ST_EXEC) begin
                ill_q <= !op_legal;
                if (op_legal && !op_mul) begin
                    result <= alu_res;
                    zero   <= (alu_res == '0);
                    carry  <= alu_c;
                end
            end
`ifdef REG_EXEC_MUL_EN
            if (state == ST_EXEC) begin
                mul_cnt   <= '0;
                mul_acc   <= '0;
                mul_mcand <= {{DW{1'b0}}, opx};
                mul_mplr  <= opy;
            end
            if (state == ST_MUL) begin
                mul_cnt   <= mul_cnt + 1'b1;
                mul_acc   <= mul_acc_nx;
                mul_mcand <= mul_mcand << 1;
                mul_mplr  <= mul_mplr >> 1;
                if (mul_last) begin
                    result <= mul_acc_nx[DW-1:0];
                    zero   <= (mul_acc_nx[DW-1:0] == '0);
                    carry  <= |mul_acc_nx[2*DW-1:DW];
                end
            end
`endif
        end
    end

    // r0 writes and undefined ops retire without touching the file.
    always_comb begin
        in_ready = (state == ST_IDLE);
        WEN      = 1'b0;
        RW       = '0;
        busW     = '0;
        done     = 1'b0;
        illegal  = 1'b0;
        if (state == ST_WB) begin
            done    = 1'b1;
            illegal = ill_q;
            RW      = AW'(instr_q.rd);
            busW    = result;
            WEN     = !ill_q && (instr_q.rd != '0);
        end
    end

endmodule

// File: tb/tb_reg_exec_ctrl.sv
// Directed bench for reg_exec_ctrl with a behavioural 8x8 register file.
// Vector table for single ops plus sequences for back-to-back and mid-op reset.
module tb_reg_exec_ctrl;
    import reg_exec_pkg::*;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        in_valid;
    logic [12:0] in_instr;
    logic        in_ready;
    logic [2:0]  RX, RY, RW;
    logic [7:0]  busX, busY, busW, result;
    logic        WEN, done, zero, carry, illegal;

    logic [7:0]  rf [8];
    logic        pl_en;
    logic [2:0]  pl_a, pl_b;
    logic [7:0]  pl_x, pl_y;
    int          cyc = 0;
    int          wen_cnt = 0;
    int          errors = 0;
    int          checks = 0;

    always #5 Clk = ~Clk;

    reg_exec_ctrl #(.DW(8), .AW(3)) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .in_valid (in_valid),
        .in_instr (in_instr),
        .in_ready (in_ready),
        .RX       (RX),
        .RY       (RY),
        .busX     (busX),
        .busY     (busY),
        .WEN      (WEN),
        .RW       (RW),
        .busW     (busW),
        .done     (done),
        .result   (result),
        .zero     (zero),
        .carry    (carry),
        .illegal  (illegal)
    );

    assign busX = (RX == 3'd0) ? 8'h00 : rf[RX];
    assign busY = (RY == 3'd0) ? 8'h00 : rf[RY];

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (WEN && RW != 3'd0) rf[RW] <= busW;
        if (pl_en) begin
            rf[pl_a] <= pl_x;
            rf[pl_b] <= pl_y;
        end
    end

    always @(negedge Clk) if (WEN) wen_cnt <= wen_cnt + 1;

    typedef struct {
        logic [3:0] op;
        logic [2:0] rd, rs, rt;
        logic [7:0] x, y, w;
        logic       wen, z, c, il;
        int         lat;
        logic [7:0] rfv;
    } vec_t;

    vec_t v[13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [2:0] a, input logic [7:0] x,
                           input logic [2:0] b, input logic [7:0] y);
        @(negedge Clk);
        pl_en = 1'b1;
        pl_a  = a;
        pl_x  = x;
        pl_b  = b;
        pl_y  = y;
        @(negedge Clk);
        pl_en = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [2:0] rd,
                         input logic [2:0] rs, input logic [2:0] rt,
                         output int lat, output logic [7:0] w,
                         output logic wen, output logic [2:0] rw,
                         output logic z, output logic c,
                         output logic il, output logic rdy_bad);
        @(negedge Clk);
        in_valid = 1'b1;
        in_instr = {op, rd, rs, rt};
        for (int k = 0; k < 20 && !in_ready; k++) @(negedge Clk);
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge Clk);
        @(negedge Clk);
        in_valid = 1'b0;
        lat = -1;
        rdy_bad = 1'b0;
        w = 8'h00; wen = 1'b0; rw = 3'd0; z = 1'b0; c = 1'b0; il = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                lat = k;
                w = busW; wen = WEN; rw = RW;
                z = zero; c = carry; il = illegal;
                break;
            end
            if (in_ready) rdy_bad = 1'b1;
            @(negedge Clk);
        end
    endtask

    initial begin
        int         lat, w0;
        logic [7:0] w;
        logic [2:0] rw;
        logic       wen, z, c, il, rb;
        logic [12:0] seq [3];
        int          acc [3];

        v[0]  = '{OP_ADD, 3'd3, 3'd1, 3'd2, 8'h7F, 8'h81, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 3, 8'h00};
        v[1]  = '{OP_SUB, 3'd4, 3'd1, 3'd2, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0, 3, 8'hFE};
        v[2]  = '{OP_SLT, 3'd5, 3'd1, 3'd2, 8'h05, 8'h07, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 3, 8'h01};
        v[3]  = '{OP_AND, 3'd6, 3'd1, 3'd2, 8'hF0, 8'h3C, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0, 3, 8'h30};
        v[4]  = '{OP_OR,  3'd6, 3'd1, 3'd2, 8'hF0, 8'h0C, 8'hFC, 1'b1, 1'b0, 1'b0, 1'b0, 3, 8'hFC};
        v[5]  = '{OP_XOR, 3'd7, 3'd1, 3'd2, 8'hAA, 8'hFF, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 3, 8'h55};
        v[6]  = '{OP_SHL, 3'd2, 3'd3, 3'd4, 8'h81, 8'h0B, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 3, 8'h08};
        v[7]  = '{OP_SHR, 3'd2, 3'd3, 3'd4, 8'h81, 8'h0B, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 3, 8'h10};
        v[8]  = '{OP_ADD, 3'd0, 3'd1, 3'd2, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 3, 8'h00};
        v[9]  = '{4'hF,   3'd3, 3'd1, 3'd2, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 3, 8'h81};
`ifdef REG_EXEC_MUL_EN
        v[10] = '{OP_MUL, 3'd5, 3'd1, 3'd2, 8'h0F, 8'h11, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 11, 8'hFF};
`else
        v[10] = '{OP_MUL, 3'd5, 3'd1, 3'd2, 8'h0F, 8'h11, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 3, 8'h01};
`endif
        v[11] = '{OP_SUB, 3'd6, 3'd1, 3'd2, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3, 8'h00};
        v[12] = '{OP_ADD, 3'd7, 3'd1, 3'd2, 8'hC0, 8'h50, 8'h10, 1'b1, 1'b0, 1'b1, 1'b0, 3, 8'h10};

        Rst_n = 1'b0;
        in_valid = 1'b0;
        in_instr = '0;
        pl_en = 1'b0;
        pl_a = 3'd0; pl_b = 3'd0; pl_x = 8'h00; pl_y = 8'h00;
        repeat (2) @(negedge Clk);
        chk("rst_ready", in_ready, 1);
        chk("rst_flags", {WEN, done, illegal, zero, carry}, 0);
        chk("rst_sel", {RX, RY, RW}, 0);
        chk("rst_data", {busW, result}, 0);
        Rst_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            preload(v[i].rs, v[i].x, v[i].rt, v[i].y);
            w0 = wen_cnt;
            issue(v[i].op, v[i].rd, v[i].rs, v[i].rt, lat, w, wen, rw, z, c, il, rb);
            @(negedge Clk);
            $display("vector %0d op=%0h", i, v[i].op);
            chk("latency", lat, v[i].lat);
            chk("busW", w, v[i].w);
            chk("wen_wb", wen, v[i].wen);
            chk("wen_count", wen_cnt - w0, int'(v[i].wen));
            chk("zero", z, v[i].z);
            chk("carry", c, v[i].c);
            chk("illegal", il, v[i].il);
            chk("ready_low_busy", rb, 0);
            if (v[i].wen) chk("rw", rw, v[i].rd);
            if (v[i].rd != 3'd0) chk("rf_after", rf[v[i].rd], v[i].rfv);
        end

        // Back-to-back with in_valid held high; r5/r6 depend on prior writes.
        preload(3'd1, 8'h03, 3'd2, 8'h04);
        seq[0] = {OP_ADD, 3'd5, 3'd1, 3'd2};
        seq[1] = {OP_SUB, 3'd6, 3'd5, 3'd1};
        seq[2] = {OP_XOR, 3'd7, 3'd6, 3'd2};
        @(negedge Clk);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_instr = seq[i];
            for (int k = 0; k < 20 && !in_ready; k++) @(negedge Clk);
            if (!in_ready) chk("b2b_timeout", 0, 1);
            acc[i] = cyc + 1;
            @(posedge Clk);
            @(negedge Clk);
        end
        in_valid = 1'b0;
        repeat (6) @(negedge Clk);
        chk("b2b_gap01", acc[1] - acc[0], 5);
        chk("b2b_gap12", acc[2] - acc[1], 5);
        chk("b2b_r5", rf[5], 8'h07);
        chk("b2b_r6", rf[6], 8'h04);
        chk("b2b_r7", rf[7], 8'h00);

        // Reset while the ADD to r5 is in EXEC.
        preload(3'd1, 8'h01, 3'd2, 8'h02);
        preload(3'd5, 8'h55, 3'd4, 8'h00);
        w0 = wen_cnt;
        @(negedge Clk);
        in_valid = 1'b1;
        in_instr = {OP_ADD, 3'd5, 3'd1, 3'd2};
        @(posedge Clk);
        @(negedge Clk);
        in_valid = 1'b0;
        repeat (2) @(negedge Clk);
        chk("exec_busy", in_ready, 0);
        Rst_n = 1'b0;
        @(negedge Clk);
        chk("abort_idle", in_ready, 1);
        chk("abort_done", done, 0);
        Rst_n = 1'b1;
        repeat (6) @(negedge Clk);
        chk("abort_wen", wen_cnt - w0, 0);
        chk("abort_r5", rf[5], 8'h55);
        issue(OP_OR, 3'd6, 3'd5, 3'd0, lat, w, wen, rw, z, c, il, rb);
        @(negedge Clk);
        chk("abort_readback", w, 8'h55);
        chk("abort_r6", rf[6], 8'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
